spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- Command sequencer between the byte-level SPI slave shifter and a small register file; runs in the `clk` domain.
- Parses each chip-select frame as a command byte followed by data bytes, then performs burst register writes or reads.
- Loads the shifter's outgoing byte and exposes register contents (LEDs, counter config) to the rest of the design.

Parameters:
- NUM_REGS, 8, number of writable 8-bit registers (power of two, 2..64).
- ADDR_W, 3, register index width = log2(NUM_REGS).
- ID_VALUE, 8'h5A, read-only value returned at address 7'h7F.
- AUTO_INC, 1, 1 = address increments after each data byte; 0 = address held.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cs_active  in  1  frame active, already synchronised to clk (1 while CE0 asserted).
- rx_byte  in  8  byte received from the shifter.
- rx_valid  in  1  one-cycle pulse: rx_byte is complete.
- tx_byte  out  8  byte presented to the shifter for the next transfer.
- tx_load  out  1  one-cycle pulse: shifter must latch tx_byte.
- regs_flat  out  NUM_REGS*8  register contents; reg i is at bits [8i+7:8i].
- wr_strobe  out  1  one-cycle pulse on each register write.
- wr_addr  out  ADDR_W  index written when wr_strobe is high.
- err_cnt  out  8  count of aborted frames, saturating at 8'hFF.
- frame_cnt  out  8  count of completed frames, wraps mod 256.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0 except tx_byte=ID_VALUE.
  - All registers 0; state IDLE; addr 0.
- States: IDLE, CMD, WDATA, RDATA, ERR.
- IDLE:
  - cs_active=1 → CMD next cycle.
  - tx_byte=ID_VALUE with a tx_load pulse in that same transition cycle, so the first clocked-out byte is the ID.
- CMD, on rx_valid:
  - cmd = rx_byte; bit7 = write, bits[6:0] = address.
  - Write to address < NUM_REGS → WDATA, addr latched.
  - Read from address < NUM_REGS → RDATA, tx_byte=reg[addr], tx_load=1 in the same cycle.
  - Read from 7'h7F → RDATA in ID mode: every later byte returns ID_VALUE and addr is not used.
  - Any other address, or a write to 7'h7F → ERR, tx_byte=8'hFF, tx_load=1.
- WDATA, each rx_valid:
  - reg[addr] ← rx_byte; wr_strobe=1 and wr_addr=addr in that cycle; the updated regs_flat is visible the following cycle.
  - If AUTO_INC, addr ← (addr+1) mod NUM_REGS, wrapping from NUM_REGS-1 to 0.
- RDATA, each rx_valid (received byte is ignored):
  - addr advances as in WDATA.
  - tx_byte=reg[new addr] with tx_load=1, giving one byte of latency: the byte after the command returns reg[addr], the next returns reg[addr+1].
- ERR:
  - rx_valid is ignored and tx_byte stays 8'hFF.
  - err_cnt increments once on entry to ERR, saturating.
- End of frame: cs_active=0 in any non-IDLE state → IDLE next cycle.
  - frame_cnt++ if the state was WDATA or RDATA.
  - CMD with no byte received: no count.
  - ERR: counted only in err_cnt.
- rx_valid and cs_active falling in the same cycle: the byte is processed fully (write committed, wr_strobe issued), then IDLE.
- rx_valid while cs_active=0: ignored.
- tx_load is never high in two consecutive cycles. wr_strobe only ever occurs in WDATA.
- Reset mid-frame: immediate return to reset values; any partial burst is abandoned.
- Arithmetic: address wrap uses an ADDR_W-bit natural overflow; counters are 8-bit.

Decomposition:
- Shared package spi_pkg holds:
  - state enum ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA, ST_ERR;
  - CMD_WR_BIT=7, ID_ADDR=7'h7F, ERR_BYTE=8'hFF.
- One natural sub-module, spi_regfile: NUM_REGS x 8 storage with a write port, a combinational read port and the flat output.
- FSM and counters stay in spi_reg_ctrl.

Test Plan:
- Reset then frame with command 8'h82 and data 8'h11, 8'h22 → reg2=8'h11, reg3=8'h22; wr_strobe twice with wr_addr 2 then 3; frame_cnt=1.
- Burst write from 8'h86 with 4 bytes (AUTO_INC=1, NUM_REGS=8) → reg6, reg7, reg0, reg1 written in that order (wrap-around).
- After writing reg5=8'h3C and reg6=8'hC3, frame with command 8'h05 and two dummy bytes → tx_byte sequence: ID_VALUE at frame start, then 8'h3C, then 8'hC3; each value with a single tx_load pulse.
- Commands 8'h7F then 8'h90, each in its own frame → first returns ID_VALUE on every byte; second enters ERR, tx_byte=8'hFF, no writes, err_cnt=1, frame_cnt unchanged.
- rx_valid coincident with cs_active falling in WDATA → write committed, state IDLE next cycle. Also assert rst_n=0 mid-burst → regs_flat=0 and tx_byte=ID_VALUE immediately.
- Apply 300 aborted frames → err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI register controller
`timescale 1ns/1ps
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int         CMD_WR_BIT = 7;
    localparam logic [6:0] ID_ADDR    = 7'h7F;
    localparam logic [7:0] ERR_BYTE   = 8'hFF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - byte-level link between the SPI shifter and the controller
`timescale 1ns/1ps
interface spi_reg_ctrl_if;

    logic       cs_active;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_load;

    // Shifter side: delivers received bytes, accepts the next byte to send.
    modport master (
        output cs_active,
        output rx_byte,
        output rx_valid,
        input  tx_byte,
        input  tx_load
    );

    // Controller side.
    modport slave (
        input  cs_active,
        input  rx_byte,
        input  rx_valid,
        output tx_byte,
        output tx_load
    );

endinterface

// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - NUM_REGS x 8 register storage with one write and one read port
`timescale 1ns/1ps
module spi_regfile #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [7:0]            wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [7:0]            rdata,
    output logic [NUM_REGS*8-1:0] regs_flat
);

    logic [7:0] mem [NUM_REGS];

    // Storage: cleared on reset, single write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = mem[g];
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI frame parser driving burst register writes and reads
`timescale 1ns/1ps
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int         NUM_REGS = 8,
    parameter int         ADDR_W   = 3,
    parameter logic [7:0] ID_VALUE = 8'h5A,
    parameter int         AUTO_INC = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_reg_ctrl_if.slave         bus,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            err_cnt,
    output logic [7:0]            frame_cnt
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              id_mode_q, id_mode_d;
    logic [7:0]        tx_q;
    logic [7:0]        tx_next;
    logic              load;
    logic              we;
    logic              err_inc;
    logic              frame_inc;

    logic [6:0]        cmd_addr;
    logic              cmd_wr;
    logic              in_range;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        rdata;

    assign cmd_addr = bus.rx_byte[6:0];
    assign cmd_wr   = bus.rx_byte[CMD_WR_BIT];
    assign in_range = (cmd_addr < 7'(NUM_REGS));
    assign addr_inc = (AUTO_INC != 0) ? addr_q + ADDR_W'(1) : addr_q;

    // While decoding the command the read port looks at the commanded
    // address; during a read burst it looks one step ahead.
    assign raddr = (state_q == ST_CMD) ? cmd_addr[ADDR_W-1:0] : addr_inc;

    spi_regfile #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (addr_q),
        .wdata     (bus.rx_byte),
        .raddr     (raddr),
        .rdata     (rdata),
        .regs_flat (regs_flat)
    );

    // Next-state, address and strobe decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_mode_d = id_mode_q;
        tx_next   = tx_q;
        load      = 1'b0;
        we        = 1'b0;
        err_inc   = 1'b0;
        frame_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cs_active) begin
                    state_d   = ST_CMD;
                    id_mode_d = 1'b0;
                    load      = 1'b1;
                    tx_next   = ID_VALUE;
                end
            end
            ST_CMD: begin
                if (!bus.cs_active) begin
                    state_d = ST_IDLE;
                end else if (bus.rx_valid) begin
                    if (cmd_wr && in_range) begin
                        state_d = ST_WDATA;
                        addr_d  = cmd_addr[ADDR_W-1:0];
                    end else if (!cmd_wr && in_range) begin
                        state_d = ST_RDATA;
                        addr_d  = cmd_addr[ADDR_W-1:0];
                        load    = 1'b1;
                        tx_next = rdata;
                    end else if (!cmd_wr && cmd_addr == ID_ADDR) begin
                        state_d   = ST_RDATA;
                        id_mode_d = 1'b1;
                        load      = 1'b1;
                        tx_next   = ID_VALUE;
                    end else begin
                        state_d = ST_ERR;
                        load    = 1'b1;
                        tx_next = ERR_BYTE;
                        err_inc = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                // A byte arriving with the falling chip select still commits.
                if (bus.rx_valid) begin
                    we     = 1'b1;
                    addr_d = addr_inc;
                end
                if (!bus.cs_active) begin
                    state_d   = ST_IDLE;
                    frame_inc = 1'b1;
                end
            end
            ST_RDATA: begin
                if (bus.rx_valid) begin
                    if (!id_mode_q) begin
                        addr_d = addr_inc;
                    end
                    if (bus.cs_active) begin
                        load    = 1'b1;
                        tx_next = id_mode_q ? ID_VALUE : rdata;
                    end
                end
                if (!bus.cs_active) begin
                    state_d   = ST_IDLE;
                    frame_inc = 1'b1;
                end
            end
            ST_ERR: begin
                if (!bus.cs_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The load pulse is masked during reset so outputs sit at their reset values.
    assign bus.tx_load = load & rst_n;
    assign bus.tx_byte = bus.tx_load ? tx_next : tx_q;
    assign wr_strobe   = we;
    assign wr_addr     = addr_q;

    // State, address, held transmit byte and frame counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            id_mode_q <= 1'b0;
            tx_q      <= ID_VALUE;
            err_cnt   <= 8'h00;
            frame_cnt <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            id_mode_q <= id_mode_d;
            if (load) begin
                tx_q <= tx_next;
            end
            if (err_inc) begin
                err_cnt <= sat_inc8(err_cnt);
            end
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard bench for spi_reg_ctrl
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

    localparam int         NR  = 8;
    localparam int         AW  = 3;
    localparam logic [7:0] IDV = 8'h5A;

    logic          clk;
    logic          rst_n;
    logic [NR*8-1:0] regs_flat;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic [7:0]    err_cnt;
    logic [7:0]    frame_cnt;

    spi_reg_ctrl_if bus ();

    spi_reg_ctrl #(
        .NUM_REGS (NR),
        .ADDR_W   (AW),
        .ID_VALUE (IDV),
        .AUTO_INC (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .err_cnt   (err_cnt),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] m_regs [NR];
    logic [7:0] m_err;
    logic [7:0] m_frame;
    logic [7:0] exp_tx [$];
    int         exp_wr [$];
    logic [7:0] fdata [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT loads a byte or writes.
    logic prev_load = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_load) begin
                chk("tx_load_back_to_back", {63'd0, prev_load}, 64'd0);
                if (exp_tx.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got load of %h expected none", bus.tx_byte);
                end else begin
                    chk("tx_byte", {56'd0, bus.tx_byte}, {56'd0, exp_tx.pop_front()});
                end
            end
            if (wr_strobe) begin
                if (exp_wr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got write to %0d expected none", wr_addr);
                end else begin
                    chk("wr_addr", {61'd0, wr_addr}, 64'(exp_wr.pop_front()));
                end
            end
            prev_load = bus.tx_load;
        end else begin
            prev_load = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_err   = 8'h00;
        m_frame = 8'h00;
    endtask

    task automatic check_all(input string tag);
        logic [NR*8-1:0] e;
        for (int i = 0; i < NR; i++) e[8*i +: 8] = m_regs[i];
        chk({tag, "_regs"}, 64'(regs_flat), 64'(e));
        chk({tag, "_err_cnt"}, {56'd0, err_cnt}, {56'd0, m_err});
        chk({tag, "_frame_cnt"}, {56'd0, frame_cnt}, {56'd0, m_frame});
    endtask

    // One chip-select frame: command byte then n bytes from fdata.
    // With coinc set, the last byte arrives in the cycle chip select drops.
    task automatic frame(input logic [7:0] cmd, input int n, input bit coinc);
        int ai;
        exp_tx.push_back(IDV);
        ai = int'(cmd[6:0]);
        if (ai < NR) begin
            if (cmd[7]) begin
                for (int i = 0; i < n; i++) begin
                    exp_wr.push_back(ai);
                    m_regs[ai] = fdata[i];
                    ai = (ai + 1) % NR;
                end
            end else begin
                exp_tx.push_back(m_regs[ai]);
                for (int i = 0; i < n; i++) begin
                    ai = (ai + 1) % NR;
                    if (!(coinc && i == n - 1)) exp_tx.push_back(m_regs[ai]);
                end
            end
            m_frame = m_frame + 8'd1;
        end else if (ai == 127 && !cmd[7]) begin
            exp_tx.push_back(IDV);
            for (int i = 0; i < n; i++) begin
                if (!(coinc && i == n - 1)) exp_tx.push_back(IDV);
            end
            m_frame = m_frame + 8'd1;
        end else begin
            exp_tx.push_back(8'hFF);
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end

        bus.cs_active = 1'b1;
        tick();
        tick();
        tick();
        bus.rx_byte  = cmd;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            bus.rx_byte  = fdata[i];
            bus.rx_valid = 1'b1;
            if (coinc && i == n - 1) bus.cs_active = 1'b0;
            tick();
            bus.rx_valid = 1'b0;
            if (coinc && i == n - 1) begin
                chk("coinc_frame_closed", {56'd0, frame_cnt}, {56'd0, m_frame});
            end
            tick();
            tick();
            tick();
        end
        bus.cs_active = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.cs_active = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.rx_valid  = 1'b0;
        rst_n         = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) fdata[i] = 8'h00;
        tick();
        tick();
        chk("rst_tx_byte", {56'd0, bus.tx_byte}, {56'd0, IDV});
        chk("rst_tx_load", {63'd0, bus.tx_load}, 64'd0);
        chk("rst_wr_strobe", {63'd0, wr_strobe}, 64'd0);
        chk("rst_wr_addr", {61'd0, wr_addr}, 64'd0);
        check_all("rst");
        rst_n = 1'b1;
        tick();

        // Basic two-byte write
        fdata[0] = 8'h11; fdata[1] = 8'h22;
        frame(8'h82, 2, 1'b0);
        check_all("wr82");

        // Burst write wrapping from reg7 to reg0
        fdata[0] = 8'hA1; fdata[1] = 8'hA2; fdata[2] = 8'hA3; fdata[3] = 8'hA4;
        frame(8'h86, 4, 1'b0);
        check_all("wrap");

        // Read back after writing reg5/reg6
        fdata[0] = 8'h3C; fdata[1] = 8'hC3;
        frame(8'h85, 2, 1'b0);
        fdata[0] = 8'h00; fdata[1] = 8'h00;
        frame(8'h05, 2, 1'b0);
        check_all("rd05");

        // ID read and an aborted write to an invalid address
        frame(8'h7F, 3, 1'b0);
        frame(8'h90, 2, 1'b0);
        check_all("id_err");

        // Last write byte coincident with chip select falling
        fdata[0] = 8'h55; fdata[1] = 8'h66;
        frame(8'h83, 2, 1'b1);
        check_all("coinc");

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            int   a;
            int   n;
            logic [7:0] cmd;
            a = $urandom_range(0, 11);
            n = $urandom_range(0, 4);
            cmd[7]   = 1'($urandom_range(0, 1));
            cmd[6:0] = (a >= 10) ? 7'h7F : 7'(a);
            for (int i = 0; i < n; i++) fdata[i] = 8'($urandom);
            frame(cmd, n, 1'b0);
            check_all("rand");
        end
        chk("queues_empty_tx", 64'(exp_tx.size()), 64'd0);
        chk("queues_empty_wr", 64'(exp_wr.size()), 64'd0);

        // Reset in the middle of a write burst
        exp_tx.push_back(IDV);
        bus.cs_active = 1'b1;
        tick();
        tick();
        bus.rx_byte  = 8'h81;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        tick();
        tick();
        bus.rx_byte  = 8'h77;
        bus.rx_valid = 1'b1;
        exp_wr.push_back(1);
        m_regs[1] = 8'h77;
        tick();
        bus.rx_valid = 1'b0;
        tick();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_tx_byte", {56'd0, bus.tx_byte}, {56'd0, IDV});
        check_all("midrst");
        bus.cs_active = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Many aborted frames drive err_cnt into saturation
        for (int f = 0; f < 300; f++) begin
            frame(8'h90, 0, 1'b0);
        end
        chk("err_saturated", {56'd0, err_cnt}, 64'hFF);
        check_all("sat");
        chk("final_tx_empty", 64'(exp_tx.size()), 64'd0);
        chk("final_wr_empty", 64'(exp_wr.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
